// File: rtl/operand_collector_pkg.sv
// Shared types and constants for the operand collector and its slots.
package collector_pkg;

  typedef enum logic {FILL, FULL} state_e;

  localparam int unsigned NCH_MAX   = 8;
  localparam int unsigned WIDTH_MAX = 16;

  // Low n bits set; callers slice down to their own channel count.
  function automatic logic [NCH_MAX-1:0] all_ones(input int unsigned n);
    logic [NCH_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NCH_MAX; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_collector_if.sv
// Operand write bus plus frame output handshake of the operand collector.
interface operand_collector_if
  import collector_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 2
) ();

  localparam int unsigned SELW = sel_width(NCH);

  logic [WIDTH-1:0]     data_bus;
  logic                 wr_en;
  logic [SELW-1:0]      sel;
  logic                 clr;
  logic                 out_ready;
  logic                 out_valid;
  logic [NCH*WIDTH-1:0] s_out;
  logic [NCH-1:0]       fill_mask;
  logic                 zero_err;
  logic                 drop_err;

  modport master (
    output data_bus, wr_en, sel, clr, out_ready,
    input  out_valid, s_out, fill_mask, zero_err, drop_err
  );

  modport slave (
    input  data_bus, wr_en, sel, clr, out_ready,
    output out_valid, s_out, fill_mask, zero_err, drop_err
  );

endinterface

// File: rtl/operand_collector_slot.sv
// One operand register with load enable and synchronous clear.
module operand_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             is_zero_o
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clr_i)     val_d = '0;
    else if (ld_i) val_d = d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign q_o       = val_q;
  assign is_zero_o = (val_q == '0);

endmodule

// File: rtl/operand_collector.sv
// Collects NCH operands from a shared bus into a frame, with optional
// zero-operand rejection, one pending frame and back-pressured output.
module operand_collector
  import collector_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NCH         = 2,
  parameter bit          ZERO_REJECT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  operand_collector_if.slave  bus
);

  localparam int unsigned        SELW   = sel_width(NCH);
  localparam logic [NCH_MAX-1:0] ONES_W = all_ones(NCH);
  localparam logic [NCH-1:0]     ONES   = ONES_W[NCH-1:0];

  state_e               state_q, state_d;
  logic [NCH-1:0]       mask_q, mask_d;
  logic                 out_valid_q, out_valid_d;
  logic [NCH*WIDTH-1:0] s_out_q, s_out_d;
  logic                 zero_err_q, zero_err_d;
  logic                 drop_err_q, drop_err_d;

  logic [WIDTH-1:0]     slot_q [NCH];
  logic [NCH-1:0]       slot_zero;
  logic [NCH-1:0]       ld;
  logic                 sel_ok, wr_acc, complete, out_free, zero_any, do_xfer;
  logic [NCH-1:0]       new_mask;
  logic [NCH*WIDTH-1:0] frame;

  assign sel_ok   = (32'(bus.sel) < NCH);
  assign wr_acc   = bus.wr_en && !bus.clr && sel_ok && (state_q == FILL);
  assign out_free = !out_valid_q || bus.out_ready;

  // Frame as it will look after this edge: the slot being written this cycle
  // contributes the bus value, so completion can transfer without a bubble.
  always_comb begin
    ld       = '0;
    frame    = '0;
    zero_any = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ld[i] = wr_acc && (bus.sel == SELW'(i));
      frame[i*WIDTH +: WIDTH] = ld[i] ? bus.data_bus : slot_q[i];
      zero_any = zero_any | (ld[i] ? (bus.data_bus == '0) : slot_zero[i]);
    end
  end

  assign new_mask = mask_q | ld;
  assign complete = wr_acc && (new_mask == ONES);

  for (genvar g = 0; g < int'(NCH); g++) begin : g_slot
    operand_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (bus.clr),
      .ld_i      (ld[g]),
      .d_i       (bus.data_bus),
      .q_o       (slot_q[g]),
      .is_zero_o (slot_zero[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    s_out_d     = s_out_q;
    zero_err_d  = 1'b0;
    drop_err_d  = bus.wr_en && !bus.clr && (!sel_ok || (state_q == FULL));
    do_xfer     = 1'b0;

    if (bus.clr) begin
      state_d = FILL;
      mask_d  = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          mask_d = new_mask;
          if (complete) begin
            if (out_free) do_xfer = 1'b1;
            else          state_d = FULL;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            do_xfer = 1'b1;
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end

    if (do_xfer) begin
      mask_d = '0;
      if (ZERO_REJECT && zero_any) begin
        zero_err_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        s_out_d     = frame;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      s_out_q     <= '0;
      zero_err_q  <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      s_out_q     <= s_out_d;
      zero_err_q  <= zero_err_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.s_out     = s_out_q;
  assign bus.fill_mask = mask_q;
  assign bus.zero_err  = zero_err_q;
  assign bus.drop_err  = drop_err_q;

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench: four collector configurations exercised with hand-computed frames.
module tb_operand_collector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  operand_collector_if #(.WIDTH(8), .NCH(2)) if2a ();
  operand_collector_if #(.WIDTH(8), .NCH(2)) if2b ();
  operand_collector_if #(.WIDTH(8), .NCH(4)) if4 ();
  operand_collector_if #(.WIDTH(8), .NCH(3)) if3 ();

  operand_collector #(.WIDTH(8), .NCH(2), .ZERO_REJECT(1'b1)) d2a (.clk(clk), .rst_n(rst_n), .bus(if2a));
  operand_collector #(.WIDTH(8), .NCH(2), .ZERO_REJECT(1'b0)) d2b (.clk(clk), .rst_n(rst_n), .bus(if2b));
  operand_collector #(.WIDTH(8), .NCH(4), .ZERO_REJECT(1'b1)) d4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  operand_collector #(.WIDTH(8), .NCH(3), .ZERO_REJECT(1'b1)) d3  (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same write to both NCH=2 instances so the ZERO_REJECT modes can be compared.
  task automatic wr2(input logic en, input logic sel, input logic [7:0] d);
    if2a.wr_en = en; if2a.sel = sel; if2a.data_bus = d;
    if2b.wr_en = en; if2b.sel = sel; if2b.data_bus = d;
  endtask

  task automatic wr4(input logic en, input logic [1:0] sel, input logic [7:0] d);
    if4.wr_en = en; if4.sel = sel; if4.data_bus = d;
  endtask

  task automatic wr3(input logic en, input logic [1:0] sel, input logic [7:0] d);
    if3.wr_en = en; if3.sel = sel; if3.data_bus = d;
  endtask

  initial begin
    wr2(1'b0, 1'b0, 8'h00); if2a.clr = 1'b0; if2b.clr = 1'b0;
    if2a.out_ready = 1'b1; if2b.out_ready = 1'b1;
    wr4(1'b0, 2'd0, 8'h00); if4.clr = 1'b0; if4.out_ready = 1'b0;
    wr3(1'b0, 2'd0, 8'h00); if3.clr = 1'b0; if3.out_ready = 1'b1;
    #12;
    chk("rst_valid", 64'(if2a.out_valid), 64'd0);
    chk("rst_sout", 64'(if4.s_out), 64'd0);
    chk("rst_mask", 64'(if3.fill_mask), 64'd0);
    chk("rst_errs", 64'({if2a.zero_err, if2a.drop_err}), 64'd0);
    rst_n = 1'b1;
    tick();

    // NCH=2 basic frame
    wr2(1'b1, 1'b0, 8'h12); tick();
    chk("n2_mask_ch0", 64'(if2a.fill_mask), 64'b01);
    chk("n2_valid_early", 64'(if2a.out_valid), 64'd0);
    wr2(1'b1, 1'b1, 8'h34); tick();
    chk("n2_valid", 64'(if2a.out_valid), 64'd1);
    chk("n2_sout", 64'(if2a.s_out), 64'h3412);
    chk("n2_mask_clear", 64'(if2a.fill_mask), 64'd0);
    wr2(1'b0, 1'b0, 8'h00); tick();
    chk("n2_valid_drop", 64'(if2a.out_valid), 64'd0);

    // zero operand: rejected on d2a, passed on d2b
    wr2(1'b1, 1'b1, 8'h05); tick();
    wr2(1'b1, 1'b0, 8'h00); tick();
    chk("zr_zero_err", 64'(if2a.zero_err), 64'd1);
    chk("zr_valid", 64'(if2a.out_valid), 64'd0);
    chk("zr_sout_held", 64'(if2a.s_out), 64'h3412);
    chk("zr_mask", 64'(if2a.fill_mask), 64'd0);
    chk("nz_valid", 64'(if2b.out_valid), 64'd1);
    chk("nz_sout", 64'(if2b.s_out), 64'h0500);
    chk("nz_zero_err", 64'(if2b.zero_err), 64'd0);
    wr2(1'b0, 1'b0, 8'h00); tick();
    chk("zr_pulse_end", 64'(if2a.zero_err), 64'd0);

    // NCH=4 back-pressure: A completes, B goes to FULL, extra write dropped
    for (int i = 0; i < 4; i++) begin
      wr4(1'b1, 2'(i), 8'(i + 1)); tick();
    end
    chk("n4_a_valid", 64'(if4.out_valid), 64'd1);
    chk("n4_a_sout", 64'(if4.s_out), 64'h04030201);
    for (int i = 0; i < 4; i++) begin
      wr4(1'b1, 2'(i), 8'(8'h0a + i)); tick();
    end
    chk("n4_full_mask", 64'(if4.fill_mask), 64'hf);
    chk("n4_hold_a", 64'(if4.s_out), 64'h04030201);
    wr4(1'b1, 2'd0, 8'hff); tick();
    chk("n4_drop_err", 64'(if4.drop_err), 64'd1);
    chk("n4_hold_a2", 64'(if4.s_out), 64'h04030201);
    chk("n4_valid_held", 64'(if4.out_valid), 64'd1);
    wr4(1'b0, 2'd0, 8'h00); if4.out_ready = 1'b1; tick();
    chk("n4_b_sout", 64'(if4.s_out), 64'h0d0c0b0a);
    chk("n4_b_valid", 64'(if4.out_valid), 64'd1);
    chk("n4_b_mask", 64'(if4.fill_mask), 64'd0);
    chk("n4_drop_end", 64'(if4.drop_err), 64'd0);
    tick();
    chk("n4_b_consumed", 64'(if4.out_valid), 64'd0);

    // NCH=3: out-of-range select, then overwrite of ch0
    wr3(1'b1, 2'd3, 8'h55); tick();
    chk("n3_drop_err", 64'(if3.drop_err), 64'd1);
    chk("n3_mask_kept", 64'(if3.fill_mask), 64'd0);
    wr3(1'b1, 2'd0, 8'h11); tick();
    chk("n3_drop_end", 64'(if3.drop_err), 64'd0);
    wr3(1'b1, 2'd0, 8'h22); tick();
    chk("n3_rewrite_mask", 64'(if3.fill_mask), 64'b001);
    chk("n3_rewrite_noerr", 64'(if3.drop_err), 64'd0);
    wr3(1'b1, 2'd1, 8'h33); tick();
    wr3(1'b1, 2'd2, 8'h44); tick();
    chk("n3_valid", 64'(if3.out_valid), 64'd1);
    chk("n3_sout", 64'(if3.s_out), 64'h443322);

    // clr beats a simultaneous write
    wr3(1'b1, 2'd0, 8'h01); tick();
    wr3(1'b1, 2'd1, 8'h02); tick();
    chk("clr_pre_mask", 64'(if3.fill_mask), 64'b011);
    wr3(1'b1, 2'd2, 8'h03); if3.clr = 1'b1; tick();
    chk("clr_mask", 64'(if3.fill_mask), 64'd0);
    chk("clr_no_drop", 64'(if3.drop_err), 64'd0);
    chk("clr_no_frame", 64'(if3.out_valid), 64'd0);
    wr3(1'b0, 2'd0, 8'h00); if3.clr = 1'b0; tick();
    chk("clr_after_mask", 64'(if3.fill_mask), 64'd0);

    // Async reset mid-cycle with a frame held and a partial frame pending
    if4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr4(1'b1, 2'(i), 8'(i + 5)); tick();
    end
    wr4(1'b1, 2'd0, 8'h09); tick();
    chk("ar_pre_valid", 64'(if4.out_valid), 64'd1);
    chk("ar_pre_mask", 64'(if4.fill_mask), 64'b0001);
    wr4(1'b0, 2'd0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(if4.out_valid), 64'd0);
    chk("ar_sout", 64'(if4.s_out), 64'd0);
    chk("ar_mask", 64'(if4.fill_mask), 64'd0);
    chk("ar_errs", 64'({if4.zero_err, if4.drop_err}), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_after_mask", 64'(if4.fill_mask), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/operand_collector.md
# operand_collector

Parametrised successor to the two-operand bus loader. Collects NCH operands of WIDTH bits from one shared data bus, steered by an explicit channel select. It presents the completed set as one frame on a valid/ready output, which feeds the fuzzy inference core. Adds zero-operand rejection as a mode, a one-deep pending frame, back-pressure, and error reporting, none of which the previous loader had.

## Interface
- WIDTH, 8, operand width in bits (2..16)
- NCH, 2, operands per frame (2..8)
- ZERO_REJECT, 1, 1 = discard frames containing any zero operand; 0 = pass all frames
- SELW, $clog2(NCH) (min 1), derived select width; not overridable
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_bus  in  WIDTH  operand value
- wr_en  in  1  write strobe; data_bus/sel sampled when high
- sel  in  SELW  target channel index
- clr  in  1  synchronous flush of the partial/pending frame
- out_ready  in  1  downstream accepts the frame
- out_valid  out  1  frame on s_out is valid
- s_out  out  NCH*WIDTH  frame; channel i at bits [i*WIDTH +: WIDTH]
- fill_mask  out  NCH  channels loaded in the current partial frame
- zero_err  out  1  one-cycle pulse: frame discarded for a zero operand
- drop_err  out  1  one-cycle pulse: write dropped (sel >= NCH, or capture stalled)

## Operation
- Capture side FSM, two states:
  - FILL: writes are accepted.
  - FULL: all NCH channels are loaded, and the frame waits for the output register.
- In FILL, an accepted write stores data_bus in slot[sel] and sets fill_mask[sel].
- Rewriting an already-loaded channel overwrites its value. This is legal and raises no error.
- The frame completes when (fill_mask | new bit) == all ones.
- Transfer at completion, when the output register is free (!out_valid, or out_valid && out_ready in the same cycle):
  - ZERO_REJECT=1 and any slot == 0: the frame is discarded, zero_err pulses, and out_valid/s_out are unchanged.
  - Otherwise: s_out <= slots and out_valid <= 1.
  - In both cases fill_mask <= 0 and the FSM stays in FILL.
- Completion with the output register occupied and not being accepted: go to FULL.
- FULL to FILL: on the first edge where out_ready is high. The transfer rules above apply on that edge.
- Writes in FULL are dropped and drop_err pulses.
- sel >= NCH: the write is dropped and drop_err pulses in any state.
- Output: out_valid falls on out_valid && out_ready, unless a transfer reloads it on the same edge.
- s_out is held stable while out_valid && !out_ready.
- clr: clears fill_mask and slots and returns the FSM to FILL. The output register is untouched.
  - clr has priority over wr_en. A write in the same cycle is dropped silently (no drop_err).
  - A frame in FULL is discarded by clr.
- Operands are unsigned and compared to zero over the full WIDTH. No arithmetic is performed.

## Timing
- Reset (async assert, sync-deasserted upstream):
  - out_valid=0, s_out=0, fill_mask=0, zero_err=0, drop_err=0.
  - All slots are 0 and the FSM is in FILL.
- Latency: a final write sampled at edge N gives out_valid=1 and new s_out after edge N.
- Pulses last exactly one cycle, registered, after the offending edge.
- Back-to-back frames: the final write at N and out_ready at N both occur. The old frame is consumed and the new one loaded at N, so out_valid stays 1.
- Reset mid-frame or mid-handshake: everything returns immediately to reset values, and any frame in flight is lost.
- Maximum throughput is one frame per NCH cycles.

## Structure
- Shared package collector_pkg holds:
  - the state enum (FILL, FULL);
  - the NCH_MAX=8 and WIDTH_MAX=16 constants;
  - the all-ones mask helper.
- One sub-module is natural: operand_slot.
  - One WIDTH register with load enable and sync clear.
  - Outputs the stored value and an is_zero flag.
  - Generated NCH times.
- The FSM, output register and error pulses live in operand_collector.

## Test plan
- NCH=2, ZERO_REJECT=1: write ch0=0x12 then ch1=0x34 with out_ready=1. Required: out_valid for one cycle, s_out=0x3412, fill_mask back to 0.
- Write ch1=0x05 then ch0=0x00. Required: zero_err pulse, out_valid stays 0. Repeating with ZERO_REJECT=0 gives s_out=0x0500 and out_valid=1.
- NCH=4: hold out_ready=0 after frame A completes, then load frame B fully, then write once more. Required: FSM goes to FULL, the extra write gives a drop_err pulse, and s_out holds A. Raising out_ready gives s_out=B on the next edge, with out_valid continuously 1.
- NCH=3: write with sel=3. Required: drop_err pulse and fill_mask unchanged. Then write ch0 twice (0x11, 0x22), then ch1 and ch2. Required: slot0=0x22 appears in s_out.
- Partial frame with fill_mask=0b011, then clr together with wr_en to ch2. Required: fill_mask=0, no drop_err, no frame.
- Assert rst_n=0 asynchronously mid-cycle while out_valid=1 and fill_mask≠0. Required: all outputs are 0 before the next clock edge.
